// File: rtl/ysyx_23060203_gpr_scoreboard.sv
// GPR scoreboard: per-register pending-write counters between issue and writeback.
// Optional same-cycle writeback forwarding under `SCOREBOARD_BYPASS_EN.
module ysyx_23060203_gpr_scoreboard #(
    parameter int NR_REG = 16,
    parameter int CNT_W  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [4:0]  iss_rs1,
    input  logic        iss_rs1_en,
    input  logic [4:0]  iss_rs2,
    input  logic        iss_rs2_en,
    input  logic [4:0]  iss_rd,
    input  logic        iss_rd_en,
    input  logic        wb_valid,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        cs_flush,
    output logic        idle,
    output logic        rs1_fwd,
    output logic        rs2_fwd,
    output logic [31:0] rs_fwd_data
);

    localparam int AW = $clog2(NR_REG);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt [NR_REG];

    logic [AW-1:0] w_rs1;
    logic [AW-1:0] w_rs2;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_wa;
    logic          w_inc;
    logic          w_dec;
    logic          w_byp1;
    logic          w_byp2;
    logic          w_haz;
    logic          w_unused;

    assign w_rs1 = iss_rs1[AW-1:0];
    assign w_rs2 = iss_rs2[AW-1:0];
    assign w_rd  = iss_rd[AW-1:0];
    assign w_wa  = wb_waddr[AW-1:0];

    assign w_dec = wb_valid & (w_wa != '0) & ~cs_flush;

`ifdef SCOREBOARD_BYPASS_EN
    // A source whose only pending write retires this cycle is taken from WB.
    assign w_byp1 = w_dec & (w_wa == w_rs1) & (r_cnt[w_rs1] == ONE);
    assign w_byp2 = w_dec & (w_wa == w_rs2) & (r_cnt[w_rs2] == ONE);
    assign rs1_fwd = ~reset & iss_rs1_en & w_byp1;
    assign rs2_fwd = ~reset & iss_rs2_en & w_byp2;
    assign rs_fwd_data = reset ? 32'd0 : wb_wdata;
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
    assign rs1_fwd = 1'b0;
    assign rs2_fwd = 1'b0;
    assign rs_fwd_data = 32'd0;
`endif

    assign w_haz = (iss_rs1_en & (r_cnt[w_rs1] != '0) & ~w_byp1)
                 | (iss_rs2_en & (r_cnt[w_rs2] != '0) & ~w_byp2)
                 | (iss_rd_en & (r_cnt[w_rd] == MAX));

    assign iss_ready = ~reset & ~cs_flush & ~w_haz;
    assign w_inc = iss_valid & iss_ready & iss_rd_en & (w_rd != '0);

    always_comb begin
        idle = 1'b1;
        for (int r = 1; r < NR_REG; r++) begin
            if (r_cnt[r] != '0) idle = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        r_cnt[0] <= '0;
        for (int r = 1; r < NR_REG; r++) begin
            if (reset || cs_flush) begin
                r_cnt[r] <= '0;
            end else begin
                if (w_inc && (w_rd == AW'(r)) &&
                    !(w_dec && (w_wa == AW'(r)))) begin
                    r_cnt[r] <= r_cnt[r] + ONE;
                end else if (w_dec && (w_wa == AW'(r)) &&
                             !(w_inc && (w_rd == AW'(r))) &&
                             (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - ONE;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && w_dec && (r_cnt[w_wa] == '0)) begin
            $error("gpr_scoreboard: writeback to x%0d with no pending write",
                   w_wa);
        end
    end
`endif

    assign w_unused = &{1'b0, iss_rs1[4:AW], iss_rs2[4:AW], iss_rd[4:AW],
                        wb_waddr[4:AW], wb_wdata};

endmodule

// File: tb/tb_ysyx_23060203_gpr_scoreboard.sv
// Directed bench for the GPR scoreboard: reset, RAW, WAW saturation,
// same-cycle inc/dec, flush, x0, address truncation and mid-run reset.
module tb_ysyx_23060203_gpr_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rs1;
    logic        iss_rs1_en;
    logic [4:0]  iss_rs2;
    logic        iss_rs2_en;
    logic [4:0]  iss_rd;
    logic        iss_rd_en;
    logic        wb_valid;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        cs_flush;
    logic        idle;
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic [31:0] rs_fwd_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    ysyx_23060203_gpr_scoreboard dut (
        .clock       (clock),
        .reset       (reset),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_rs1     (iss_rs1),
        .iss_rs1_en  (iss_rs1_en),
        .iss_rs2     (iss_rs2),
        .iss_rs2_en  (iss_rs2_en),
        .iss_rd      (iss_rd),
        .iss_rd_en   (iss_rd_en),
        .wb_valid    (wb_valid),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .cs_flush    (cs_flush),
        .idle        (idle),
        .rs1_fwd     (rs1_fwd),
        .rs2_fwd     (rs2_fwd),
        .rs_fwd_data (rs_fwd_data)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic quiet;
        iss_valid  = 1'b0;
        iss_rs1    = '0;
        iss_rs1_en = 1'b0;
        iss_rs2    = '0;
        iss_rs2_en = 1'b0;
        iss_rd     = '0;
        iss_rd_en  = 1'b0;
        wb_valid   = 1'b0;
        wb_waddr   = '0;
        wb_wdata   = '0;
        cs_flush   = 1'b0;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
        iss_rd_en = 1'b1;
    endtask

    task automatic wb(input logic [4:0] a);
        wb_valid = 1'b1;
        wb_waddr = a;
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        iss_valid  = 1'b1;
        iss_rs1    = 5'd3;
        iss_rs1_en = 1'b1;
        issue_rd(5'd4);
        tick();
        check("rst_ready_c0", {31'd0, iss_ready}, 0);
        tick();
        check("rst_ready_c1", {31'd0, iss_ready}, 0);
        check("rst_fwd", {31'd0, rs1_fwd}, 0);
        check("rst_fdata", rs_fwd_data, 0);
        reset = 1'b0;
        iss_valid = 1'b0;
        #1;
        check("idle_after_rst", {31'd0, idle}, 1);
        check("ready_no_valid", {31'd0, iss_ready}, 1);

        // RAW on x5
        quiet();
        issue_rd(5'd5);
        #1 check("raw_issue_rd", {31'd0, iss_ready}, 1);
        tick();
        quiet();
        iss_valid  = 1'b1;
        iss_rs1    = 5'd5;
        iss_rs1_en = 1'b1;
        #1 check("raw_stall0", {31'd0, iss_ready}, 0);
        check("raw_busy", {31'd0, idle}, 0);
        tick();
        check("raw_stall1", {31'd0, iss_ready}, 0);
        wb(5'd5);
        wb_wdata = 32'hDEADBEEF;
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        check("raw_byp_ready", {31'd0, iss_ready}, 1);
        check("raw_byp_fwd", {31'd0, rs1_fwd}, 1);
        check("raw_byp_data", rs_fwd_data, 32'hDEADBEEF);
        tick();
        wb_valid = 1'b0;
        #1 check("raw_idle", {31'd0, idle}, 1);
`else
        check("raw_wb_cycle", {31'd0, iss_ready}, 0);
        check("raw_nofwd", {31'd0, rs1_fwd}, 0);
        tick();
        wb_valid = 1'b0;
        #1 check("raw_after_wb", {31'd0, iss_ready}, 1);
        check("raw_idle", {31'd0, idle}, 1);
        tick();
`endif

        // WAW saturation on x7
        quiet();
        issue_rd(5'd7);
        for (int i = 0; i < 3; i++) begin
            #1 check("waw_issue", {31'd0, iss_ready}, 1);
            tick();
        end
        check("waw_sat", {31'd0, iss_ready}, 0);
        wb(5'd7);
        #1 check("waw_sat_wb", {31'd0, iss_ready}, 0);
        tick();
        wb_valid = 1'b0;
        #1 check("waw_unblock", {31'd0, iss_ready}, 1);
        tick();
        check("waw_sat_again", {31'd0, iss_ready}, 0);
        quiet();
        wb(5'd7);
        for (int i = 0; i < 3; i++) tick();
        wb_valid = 1'b0;
        #1 check("waw_drained", {31'd0, idle}, 1);

        // simultaneous inc and dec on x9
        quiet();
        issue_rd(5'd9);
        tick();
        wb(5'd9);
        #1 check("incdec_ready", {31'd0, iss_ready}, 1);
        tick();
        quiet();
        check("incdec_busy", {31'd0, idle}, 0);
        iss_rs1    = 5'd9;
        iss_rs1_en = 1'b1;
        #1 check("incdec_stall", {31'd0, iss_ready}, 0);
        wb(5'd9);
        tick();
        quiet();
        #1 check("incdec_cnt1", {31'd0, idle}, 1);

        // flush with cnt[2]=1, cnt[6]=2
        issue_rd(5'd2);
        tick();
        issue_rd(5'd6);
        tick();
        tick();
        quiet();
        #1 check("flush_pre_busy", {31'd0, idle}, 0);
        cs_flush = 1'b1;
        wb(5'd2);
        issue_rd(5'd3);
        #1 check("flush_ready", {31'd0, iss_ready}, 0);
        tick();
        quiet();
        #1 check("flush_idle", {31'd0, idle}, 1);
        iss_rs1    = 5'd6;
        iss_rs1_en = 1'b1;
        iss_rs2    = 5'd3;
        iss_rs2_en = 1'b1;
        #1 check("flush_clear", {31'd0, iss_ready}, 1);

        // x0 never tracked
        quiet();
        issue_rd(5'd0);
        iss_rs1_en = 1'b1;
        wb(5'd0);
        for (int i = 0; i < 10; i++) begin
            #1 check("x0_ready", {31'd0, iss_ready}, 1);
            tick();
        end
        check("x0_idle", {31'd0, idle}, 1);

        // upper address bits ignored: x19 aliases x3
        quiet();
        issue_rd(5'h13);
        tick();
        quiet();
        iss_rs2    = 5'd3;
        iss_rs2_en = 1'b1;
        #1 check("alias_stall", {31'd0, iss_ready}, 0);
        wb(5'h13);
        tick();
        wb_valid = 1'b0;
        #1 check("alias_ready", {31'd0, iss_ready}, 1);
        check("alias_idle", {31'd0, idle}, 1);

        // reset mid-operation drops pending state
        quiet();
        issue_rd(5'd4);
        tick();
        quiet();
        #1 check("mrst_busy", {31'd0, idle}, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 check("mrst_idle", {31'd0, idle}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
